// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port (fetch, load/store) memory arbiter; optional timeout via ARB_TIMEOUT_EN
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt_sys,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_fetch,
  output logic              err
);

  // Starvation counter is at least 2 bits wide, wider if STARVE_MAX needs it.
  localparam int SCW = ($clog2(STARVE_MAX + 1) > 2) ? $clog2(STARVE_MAX + 1) : 2;

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SCW-1:0]    starve_cnt;
  logic              grant_fetch;
  logic              grant_data;
  logic              done;
  logic              timeout;
  logic              busy;

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and grant decisions; load/store wins unless fetch has waited STARVE_MAX grants.
  always_comb begin
    state_nxt   = state;
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (!halt_sys) begin
          if (ls_req && !(if_req && (starve_cnt == SCW'(STARVE_MAX)))) begin
            grant_data = 1'b1;
            state_nxt  = DATA;
          end else if (if_req) begin
            grant_fetch = 1'b1;
            state_nxt   = FETCH;
          end
        end
      end
      FETCH, DATA: begin
        if (mem_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the granted requester's access so the requester's bus may change after ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (grant_data) begin
      addr_q  <= ls_addr;
      we_q    <= ls_we;
      wdata_q <= ls_wdata;
    end else if (grant_fetch) begin
      addr_q  <= if_addr;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end
  end

  // Count data grants that bypassed a waiting fetch; a fetch grant clears the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_fetch) begin
      starve_cnt <= '0;
    end else if (grant_data && if_req && (starve_cnt != SCW'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Registered one-cycle ack pulses; store completions return zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_ack   <= 1'b0;
      if_rdata <= '0;
      ls_ack   <= 1'b0;
      ls_rdata <= '0;
    end else begin
      if_ack   <= done && (state == FETCH);
      if_rdata <= (done && (state == FETCH)) ? mem_rdata : '0;
      ls_ack   <= done && (state == DATA);
      ls_rdata <= (done && (state == DATA) && !we_q) ? mem_rdata : '0;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [3:0] tmo_cnt;
  logic       err_q;

  // The 15th busy cycle without mem_ready abandons the access.
  assign timeout = busy && !mem_ready && (tmo_cnt == 4'd14);

  // Busy-cycle counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      if (busy && !mem_ready && !timeout) tmo_cnt <= tmo_cnt + 4'd1;
      else                                tmo_cnt <= 4'd0;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign busy        = (state != IDLE);
  assign mem_en      = busy;
  assign mem_we      = (state == DATA) && we_q;
  assign mem_addr    = busy ? addr_q  : '0;
  assign mem_wdata   = busy ? wdata_q : '0;
  assign stall_fetch = if_req && !if_ack && !rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt_sys = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [15:0] ls_addr = '0;
  logic [15:0] ls_wdata = '0;
  logic        ls_ack;
  logic [15:0] ls_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        stall_fetch;
  logic        err;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_fetch(stall_fetch), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } grant_t;

  grant_t      gq[$];
  logic [15:0] if_q[$];
  logic [15:0] ls_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  // Memory model: unwritten words follow a fixed pattern, 0x0010 holds 0xA5A5.
  bit [15:0] mem_model [256];
  bit        written [256];
  bit        force_ready = 1'b0;
  bit        auto_ready = 1'b1;
  int        ready_delay = 0;
  int        busy_cyc = 0;

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    if (written[a[7:0]]) return mem_model[a[7:0]];
    if (a == 16'h0010) return 16'hA5A5;
    return {a[7:0], ~a[7:0]};
  endfunction

  assign mem_rdata = model_rd(mem_addr);
  assign mem_ready = force_ready | (mem_en & auto_ready & (busy_cyc >= ready_delay));

  always @(posedge clk) begin
    busy_cyc <= (mem_en && !mem_ready) ? busy_cyc + 1 : 0;
    if (mem_en && mem_we && mem_ready) begin
      mem_model[mem_addr[7:0]] <= mem_wdata;
      written[mem_addr[7:0]]   <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Grant monitor: each new access is compared against the expected grant order.
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (mem_en && !prev_en) begin
      if (gq.size() == 0) begin
        check("grant_unexpected", 1, 0);
      end else begin
        grant_t e;
        e = gq.pop_front();
        check("grant_addr", mem_addr, e.addr);
        check("grant_we", mem_we, e.we);
        if (e.we) check("grant_wdata", mem_wdata, e.wdata);
      end
    end
    prev_en = mem_en;
  end

  // Ack monitor: acks must be exclusive and carry the expected data.
  always @(negedge clk) begin
    if (if_ack || ls_ack) check("ack_exclusive", if_ack & ls_ack, 0);
    if (if_ack) begin
      if (if_q.size() == 0) check("if_ack_unexpected", 1, 0);
      else check("if_rdata", if_rdata, if_q.pop_front());
    end
    if (ls_ack) begin
      if (ls_q.size() == 0) check("ls_ack_unexpected", 1, 0);
      else check("ls_rdata", ls_rdata, ls_q.pop_front());
    end
  end

  function automatic bit sig_val(input int which);
    case (which)
      0:       return if_ack;
      1:       return ls_ack;
      default: return mem_en;
    endcase
  endfunction

  task automatic wait_for(input int which, input int limit, output int n);
    n = 0;
    while (!sig_val(which) && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Fetch requester: keeps if_req high across cnt back-to-back accesses.
  task automatic fetch_txns(input int cnt, input logic [15:0] base, input bit lat_chk);
    int n;
    @(negedge clk);
    if_req = 1'b1;
    for (int k = 0; k < cnt; k++) begin
      if_addr = base + 16'(k);
      if_q.push_back(model_rd(if_addr));
      @(negedge clk);
      wait_for(0, 60, n);
      check("if_ack_seen", if_ack, 1);
      if (lat_chk) check("if_latency", n + 1, 2);
    end
    if_req = 1'b0;
  endtask

  // Load/store requester: keeps ls_req high across cnt back-to-back accesses.
  task automatic ls_txns(input int cnt, input logic [15:0] base, input bit we, input logic [15:0] wd);
    int n;
    @(negedge clk);
    ls_req = 1'b1;
    for (int k = 0; k < cnt; k++) begin
      ls_addr  = base + 16'(k);
      ls_we    = we;
      ls_wdata = wd;
      ls_q.push_back(we ? 16'h0000 : model_rd(ls_addr));
      @(negedge clk);
      wait_for(1, 60, n);
      check("ls_ack_seen", ls_ack, 1);
    end
    ls_req = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_acks", {if_ack, ls_ack}, 0);
    check("rst_err", err, 0);
    check("rst_stall", stall_fetch, 0);
    rst = 1'b0;

    // Isolated fetch with minimum latency
    gq.push_back('{we: 1'b0, addr: 16'h0010, wdata: 16'h0});
    fetch_txns(1, 16'h0010, 1'b1);

    // mem_ready while idle must not start or complete anything
    force_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready_ignored", mem_en, 0);
    end
    force_ready = 1'b0;

    // Plain load
    gq.push_back('{we: 1'b0, addr: 16'h0020, wdata: 16'h0});
    ls_txns(1, 16'h0020, 1'b0, 16'h0);

    // Simultaneous requests: store first, fetch next
    gq.push_back('{we: 1'b1, addr: 16'h0040, wdata: 16'h1234});
    gq.push_back('{we: 1'b0, addr: 16'h0030, wdata: 16'h0});
    fork
      fetch_txns(1, 16'h0030, 1'b0);
      ls_txns(1, 16'h0040, 1'b1, 16'h1234);
    join
    check("store_written", model_rd(16'h0040), 16'h1234);

    // Starvation: three data grants, one fetch, then the pattern restarts from zero
    for (int k = 0; k < 3; k++) gq.push_back('{we: 1'b0, addr: 16'h00A0 + 16'(k), wdata: 16'h0});
    gq.push_back('{we: 1'b0, addr: 16'h0090, wdata: 16'h0});
    for (int k = 3; k < 6; k++) gq.push_back('{we: 1'b0, addr: 16'h00A0 + 16'(k), wdata: 16'h0});
    gq.push_back('{we: 1'b0, addr: 16'h0091, wdata: 16'h0});
    fork
      fetch_txns(2, 16'h0090, 1'b0);
      ls_txns(6, 16'h00A0, 1'b0, 16'h0);
    join

    // halt_sys during a data access: access completes, nothing new starts until release
    ready_delay = 2;
    gq.push_back('{we: 1'b0, addr: 16'h0050, wdata: 16'h0});
    gq.push_back('{we: 1'b0, addr: 16'h0060, wdata: 16'h0});
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0050;
    ls_q.push_back(model_rd(16'h0050));
    @(negedge clk);
    wait_for(2, 10, n);
    check("halt_data_started", mem_en, 1);
    halt_sys = 1'b1;
    if_req = 1'b1; if_addr = 16'h0060;
    if_q.push_back(model_rd(16'h0060));
    wait_for(1, 20, n);
    check("halt_ls_ack", ls_ack, 1);
    ls_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("halt_block", mem_en, 0);
    end
    halt_sys = 1'b0;
    wait_for(0, 20, n);
    check("halt_release_ack", if_ack, 1);
    if_req = 1'b0;
    ready_delay = 0;

    // Reset in the middle of a fetch aborts it without an ack
    auto_ready = 1'b0;
    gq.push_back('{we: 1'b0, addr: 16'h0070, wdata: 16'h0});
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0070;
    @(negedge clk);
    wait_for(2, 10, n);
    @(negedge clk);
    check("abort_in_fetch", mem_en, 1);
    rst = 1'b1;
    #1;
    check("abort_mem_en", mem_en, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_err", err, 0);
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    auto_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_ack", {if_ack, mem_en}, 0);
    end

    // Memory that never answers
    auto_ready = 1'b0;
    gq.push_back('{we: 1'b0, addr: 16'h0080, wdata: 16'h0});
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0080;
    @(negedge clk);
    wait_for(2, 10, n);
`ifdef ARB_TIMEOUT_EN
    cnt = 0;
    while (mem_en && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    if_req = 1'b0;
    check("timeout_cycles", cnt, 15);
    check("timeout_err", err, 1);
    check("timeout_no_ack", if_ack, 0);
    repeat (3) @(negedge clk);
    check("timeout_err_sticky", err, 1);
    auto_ready = 1'b1;
`else
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt++;
    end
    check("wait_still_busy", mem_en, 1);
    check("wait_err", err, 0);
    check("wait_stall_fetch", stall_fetch, 1);
    if_q.push_back(model_rd(16'h0080));
    auto_ready = 1'b1;
    wait_for(0, 10, n);
    check("wait_late_ack", if_ack, 1);
    if_req = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("grant_queue_drained", gq.size(), 0);
    check("if_queue_drained", if_q.size(), 0);
    check("ls_queue_drained", ls_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL provide parameter ADDR_W, default 16, address width.
REQ-002 SHALL provide parameter DATA_W, default 16, data width.
REQ-003 SHALL provide parameter STARVE_MAX, default 3, max consecutive data grants while fetch waits.
REQ-004 SHALL provide ports as follows (clock and reset first):
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- halt_sys  in  1  blocks new grants.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  fetch completion, one-cycle pulse.
- if_rdata  out  DATA_W  fetched word, valid with if_ack.
- ls_req  in  1  load/store request.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ls_ack  out  1  load/store completion, one-cycle pulse.
- ls_rdata  out  DATA_W  load data, valid with ls_ack.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completes the current access this cycle.
- stall_fetch  out  1  fetch pending and not acknowledged this cycle.
- err  out  1  sticky timeout flag.

Function
REQ-005 SHALL implement FSM states IDLE, FETCH, DATA; reset state IDLE.
REQ-006 In IDLE with halt_sys=0: ls_req=1 -> DATA, unless if_req=1 and starve_cnt==STARVE_MAX, then -> FETCH; if_req only -> FETCH; neither -> IDLE.
REQ-007 In IDLE with halt_sys=1, SHALL stay in IDLE; an access already in progress SHALL complete.
REQ-008 SHALL latch the granted request's address/we/wdata on entry to FETCH/DATA; requesters SHALL hold the request stable until ack.
REQ-009 In FETCH/DATA SHALL drive mem_en=1, mem_addr/mem_wdata from the latched values; mem_we = latched ls_we in DATA, 0 in FETCH; all mem_* outputs 0 in IDLE.
REQ-010 On mem_ready=1 in FETCH/DATA SHALL return to IDLE and, at the next edge, register a one-cycle ack pulse on the granted port with rdata=mem_rdata (rdata for stores SHALL be 0).
REQ-011 Minimum latency: request sampled at edge N, mem_ready in cycle N+1 -> ack high in cycle N+2; back-to-back grants SHALL leave one IDLE cycle between accesses.
REQ-012 starve_cnt (2-bit minimum, saturating at STARVE_MAX) SHALL increment on each DATA grant made while if_req=1 and clear on each FETCH grant.
REQ-013 mem_ready in IDLE SHALL be ignored.
REQ-014 stall_fetch = if_req & ~if_ack (combinational).
REQ-015 if_ack and ls_ack SHALL never be high in the same cycle.

Reset
REQ-016 rst=1 SHALL immediately force state IDLE and starve_cnt=0, clear err, drive all outputs to 0, and abort any in-flight access without an ack.
REQ-017 After rst deassertion, the first grant SHALL occur no earlier than the first rising edge.

Configuration
REQ-018 Macro ARB_TIMEOUT_EN defined: a 4-bit counter SHALL count cycles in FETCH/DATA; at 15 cycles without mem_ready, the arbiter SHALL return to IDLE with no ack, set err=1 (sticky until rst), and clear the counter.
REQ-019 Macro ARB_TIMEOUT_EN undefined: err SHALL be tied to 0, no timeout counter SHALL exist, and the FSM SHALL wait indefinitely for mem_ready.

Verification
REQ-020 Fetch only: if_req=1, if_addr=0x0010, mem_rdata=0xA5A5, mem_ready one cycle after grant -> if_ack=1 with if_rdata=0xA5A5 exactly 2 cycles after the request edge.
REQ-021 Simultaneous requests: if_req=ls_req=1, ls_we=1, ls_addr=0x0040, ls_wdata=0x1234 -> DATA granted first, mem_we=1, mem_addr=0x0040; FETCH granted next.
REQ-022 Starvation: ls_req held at 1, if_req held at 1 -> exactly 3 DATA grants, then one FETCH grant, then starve_cnt=0.
REQ-023 halt_sys=1 asserted mid-DATA -> current access acks; no further mem_en until halt_sys=0.
REQ-024 rst pulsed while in FETCH with mem_ready=0 -> mem_en=0 immediately, no if_ack, state IDLE.
REQ-025 With ARB_TIMEOUT_EN defined and mem_ready held at 0 -> after 15 cycles in FETCH, return to IDLE, err=1, if_ack never asserted.
